// File: rtl/mopshub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mopshub_seq_pkg
// Description : Shared types and default constants for the MOPSHUB test
//               sequencer. Holds the state enum, the default durations and a
//               helper that flags the states covered by the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package mopshub_seq_pkg;

    localparam int SEQ_CNT_W = 24;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_TRIM        = 4'd1,
        ST_WAIT_SIGNON = 4'd2,
        ST_RX          = 4'd3,
        ST_ENDWAIT     = 4'd4,
        ST_GAP         = 4'd5,
        ST_TX          = 4'd6,
        ST_DONE        = 4'd7,
        ST_ERR         = 4'd8
    } seq_state_t;

    localparam logic [SEQ_CNT_W-1:0] SEQ_GAP_CYCLES     = 24'd120;
    localparam logic [SEQ_CNT_W-1:0] SEQ_ENDWAIT_CYCLES = 24'd1;
    localparam logic [SEQ_CNT_W-1:0] SEQ_TIMEOUT_CYCLES = 24'd4_000_000;
    localparam logic [7:0]           SEQ_N_LOOPS        = 8'd1;

    // States that wait on an external strobe and therefore need a watchdog.
    function automatic logic seq_watched(input seq_state_t s);
        return (s == ST_TRIM) || (s == ST_WAIT_SIGNON) ||
               (s == ST_RX)   || (s == ST_TX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_cycle_counter
// Description : Loadable down-counter that stops at zero.
//   clk_40_m   in  : clock
//   rst        in  : synchronous active-low reset (count -> 0)
//   load       in  : load load_value (has priority over counting)
//   load_value in  : value to load
//   en         in  : decrement by one while non-zero
//   value      out : current count
//   zero       out : count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_cycle_counter
    import mopshub_seq_pkg::*;
(
    input  logic                 clk_40_m,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SEQ_CNT_W-1:0] load_value,
    input  logic                 en,
    output logic [SEQ_CNT_W-1:0] value,
    output logic                 zero
);

    logic [SEQ_CNT_W-1:0] r_value;

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (en && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign value = r_value;
    assign zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/mopshub_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mopshub_test_sequencer
// Description : Cycle-exact sequencer for the MOPSHUB system test:
//               TRIM -> WAIT_SIGNON -> (RX -> ENDWAIT -> GAP -> TX) x N_LOOPS
//               with a per-state watchdog and a level abort.
//   Inputs : clk_40_m, rst (sync, active-low), start, trim_en, abort,
//            end_power_init, sign_on_sig, test_rx_end, test_tx_end
//   Outputs: osc_auto_trim_mopshub, test_rx, test_tx, endwait_all (phase
//            controls), state_o, loop_cnt, done, timeout_err (status)
// Revision    : 1.0 - initial release
// ============================================================================
module mopshub_test_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter logic [SEQ_CNT_W-1:0] GAP_CYCLES     = SEQ_GAP_CYCLES,
    parameter logic [SEQ_CNT_W-1:0] ENDWAIT_CYCLES = SEQ_ENDWAIT_CYCLES,
    parameter logic [SEQ_CNT_W-1:0] TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES,
    parameter logic [7:0]           N_LOOPS        = SEQ_N_LOOPS
) (
    input  logic       clk_40_m,
    input  logic       rst,
    input  logic       start,
    input  logic       trim_en,
    input  logic       abort,
    input  logic       end_power_init,
    input  logic       sign_on_sig,
    input  logic       test_rx_end,
    input  logic       test_tx_end,
    output logic       osc_auto_trim_mopshub,
    output logic       test_rx,
    output logic       test_tx,
    output logic       endwait_all,
    output logic [3:0] state_o,
    output logic [7:0] loop_cnt,
    output logic       done,
    output logic       timeout_err
);

    // Counters are loaded with N-1 so a state lasts exactly N cycles:
    // the exit is taken in the cycle where the count has reached zero.
    localparam logic [SEQ_CNT_W-1:0] C_WD_RELOAD =
        (TIMEOUT_CYCLES == '0) ? '0 : TIMEOUT_CYCLES - 1'b1;
    localparam logic [SEQ_CNT_W-1:0] C_ENDWAIT_RELOAD = ENDWAIT_CYCLES - 1'b1;
    localparam logic [SEQ_CNT_W-1:0] C_GAP_RELOAD     = GAP_CYCLES - 1'b1;

    seq_state_t           r_state;
    seq_state_t           w_next;
    logic                 w_start_ok;
    logic                 w_signon;
    logic                 w_wd_expired;
    logic [7:0]           w_loop_inc;
    logic                 w_state_change;
    logic                 w_dur_load;
    logic [SEQ_CNT_W-1:0] w_dur_load_value;
    logic                 w_dur_zero;
    logic                 w_wd_zero;
    logic [SEQ_CNT_W-1:0] w_dur_value;
    logic [SEQ_CNT_W-1:0] w_wd_value;
    logic                 w_unused_values;

    logic                 r_signon_seen;
    logic                 r_osc;
    logic                 r_rx;
    logic                 r_tx;
    logic                 r_endwait;
    logic                 r_done;
    logic                 r_timeout;
    logic [7:0]           r_loop_cnt;

    // A live sign-on strobe counts as well as the remembered one, so the
    // RX phase starts one edge after the strobe.
    assign w_signon     = r_signon_seen | sign_on_sig;
    assign w_wd_expired = (TIMEOUT_CYCLES != '0) && seq_watched(r_state) && w_wd_zero;
    assign w_loop_inc   = (r_loop_cnt == 8'hFF) ? 8'hFF : r_loop_cnt + 8'd1;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion strobes are tested before the watchdog so they win a tie.
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    w_next     = trim_en ? ST_TRIM : ST_WAIT_SIGNON;
                end
            end
            ST_TRIM: begin
                if (end_power_init)    w_next = ST_WAIT_SIGNON;
                else if (w_wd_expired) w_next = ST_ERR;
            end
            ST_WAIT_SIGNON: begin
                if (w_signon)          w_next = ST_RX;
                else if (w_wd_expired) w_next = ST_ERR;
            end
            ST_RX: begin
                if (test_rx_end)       w_next = ST_ENDWAIT;
                else if (w_wd_expired) w_next = ST_ERR;
            end
            ST_ENDWAIT: begin
                if (w_dur_zero)        w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_dur_zero)        w_next = ST_TX;
            end
            ST_TX: begin
                if (test_tx_end)       w_next = (w_loop_inc < N_LOOPS) ? ST_RX : ST_DONE;
                else if (w_wd_expired) w_next = ST_ERR;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next     = ST_IDLE;
            w_start_ok = 1'b0;
        end
    end

    // ------------------------------------------------------------ counters
    assign w_state_change   = (w_next != r_state);
    assign w_dur_load       = w_state_change && ((w_next == ST_ENDWAIT) || (w_next == ST_GAP));
    assign w_dur_load_value = (w_next == ST_ENDWAIT) ? C_ENDWAIT_RELOAD : C_GAP_RELOAD;

    seq_cycle_counter u_dur_cnt (
        .clk_40_m   (clk_40_m),
        .rst        (rst),
        .load       (w_dur_load),
        .load_value (w_dur_load_value),
        .en         ((r_state == ST_ENDWAIT) || (r_state == ST_GAP)),
        .value      (w_dur_value),
        .zero       (w_dur_zero)
    );

    seq_cycle_counter u_wd_cnt (
        .clk_40_m   (clk_40_m),
        .rst        (rst),
        .load       (w_state_change),
        .load_value (C_WD_RELOAD),
        .en         (seq_watched(r_state)),
        .value      (w_wd_value),
        .zero       (w_wd_zero)
    );

    // Only the zero flags steer the FSM; the raw counts are not needed here.
    assign w_unused_values = ^{w_dur_value, w_wd_value};

    // ------------------------------------------------------ status/outputs
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_signon_seen <= 1'b0;
            r_osc         <= 1'b0;
            r_rx          <= 1'b0;
            r_tx          <= 1'b0;
            r_endwait     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_loop_cnt    <= 8'd0;
        end else begin
            // Phase controls are decoded from the next state so they move
            // on the same edge as state_o.
            r_osc     <= (w_next == ST_TRIM);
            r_rx      <= (w_next == ST_RX);
            r_tx      <= (w_next == ST_TX);
            r_endwait <= (w_next == ST_ENDWAIT);

            if (w_start_ok)              r_done <= 1'b0;
            else if (w_next == ST_DONE)  r_done <= 1'b1;

            if (w_start_ok)              r_timeout <= 1'b0;
            else if (w_next == ST_ERR)   r_timeout <= 1'b1;

            if (abort || w_start_ok)                r_loop_cnt <= 8'd0;
            else if ((r_state == ST_TX) && test_tx_end) r_loop_cnt <= w_loop_inc;

            // Clearing on RX entry means later loops do not need a new sign-on.
            if (abort)                                        r_signon_seen <= 1'b0;
            else if ((w_next == ST_RX) && (r_state != ST_RX)) r_signon_seen <= 1'b0;
            else if (sign_on_sig && (r_state != ST_IDLE))     r_signon_seen <= 1'b1;
        end
    end

    assign osc_auto_trim_mopshub = r_osc;
    assign test_rx               = r_rx;
    assign test_tx               = r_tx;
    assign endwait_all           = r_endwait;
    assign state_o               = r_state;
    assign loop_cnt              = r_loop_cnt;
    assign done                  = r_done;
    assign timeout_err           = r_timeout;

endmodule
`default_nettype wire
